// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and widths for the 5-stage pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int PERF_W = 16;
    localparam int WAIT_W = 8;
    localparam int LU_W   = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Load-use comparator: flags an ID source register that a load in EX has not yet produced.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    output logic             lu_hit
);

    // $zero is never a real dependency, so a load targeting it cannot stall.
    assign lu_hit = idex_memread && (idex_rt != {REG_W{1'b0}}) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flush, memory-busy freeze.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              idex_memread,
    input  logic [REG_W-1:0]  idex_rt,
    input  logic              exmem_branch_taken,
    input  logic              dmem_busy,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              pipe_hold,
    output logic              timeout_err,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_wait
);

    hz_state_e         state_q, state_d, ret_state_q, ret_state_d;
    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              lu_hit;

    load_use_detect u_lu (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .lu_hit       (lu_hit)
    );

    // Next-state and control decode; priority is busy, then branch, then load-use.
    always_comb begin
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        pipe_hold     = 1'b0;
        case (state_q)
            LU_STALL: begin
                if (dmem_busy) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_hold   = 1'b1;
                    ret_state_d = LU_STALL;
                    wait_cnt_d  = {{(WAIT_W-1){1'b0}}, 1'b1};
                    state_d     = MEM_WAIT;
                end else if (exmem_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    lu_cnt_d    = {LU_W{1'b0}};
                    state_d     = RUN;
                end else begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    lu_cnt_d   = lu_cnt_q - {{(LU_W-1){1'b0}}, 1'b1};
                    if (lu_cnt_q <= {{(LU_W-1){1'b0}}, 1'b1}) begin
                        state_d = RUN;
                    end else begin
                        state_d = LU_STALL;
                    end
                end
            end
            MEM_WAIT: begin
                // Frozen on the exit cycle too, so the held stages get one recovery cycle.
                pc_we         = 1'b0;
                ifid_we       = 1'b0;
                pipe_hold     = 1'b1;
                timeout_err_d = timeout_err_q || (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT));
                if (dmem_busy) begin
                    wait_cnt_d = (wait_cnt_q == {WAIT_W{1'b1}}) ? wait_cnt_q
                               : wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                    state_d    = MEM_WAIT;
                end else begin
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = ret_state_q;
                end
            end
            default: begin
                // RUN, and the unused code 3 which recovers into RUN.
                state_d = RUN;
                if (dmem_busy) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_hold   = 1'b1;
                    ret_state_d = RUN;
                    wait_cnt_d  = {{(WAIT_W-1){1'b0}}, 1'b1};
                    state_d     = MEM_WAIT;
                end else if (exmem_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (lu_hit) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        lu_cnt_d = LU_W'(LU_BUBBLES - 1);
                        state_d  = LU_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
        endcase
        if (!rst_n) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pipe_hold   = 1'b0;
        end else begin
            pipe_hold = pipe_hold;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            ret_state_q   <= RUN;
            lu_cnt_q      <= {LU_W{1'b0}};
            wait_cnt_q    <= {WAIT_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            lu_cnt_q      <= lu_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
    assign state_o     = state_q;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic [PERF_W-1:0] perf_wait_q, perf_wait_d;

    // A branch flush also raises idex_flush; ifid_flush separates it from a bubble.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_wait_d  = perf_wait_q;
        if (idex_flush && !ifid_flush) begin
            perf_stall_d = perf_inc(perf_stall_q);
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (ifid_flush) begin
            perf_flush_d = perf_inc(perf_flush_q);
        end else begin
            perf_flush_d = perf_flush_q;
        end
        if (state_q == MEM_WAIT) begin
            perf_wait_d = perf_inc(perf_wait_q);
        end else begin
            perf_wait_d = perf_wait_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= {PERF_W{1'b0}};
            perf_flush_q <= {PERF_W{1'b0}};
            perf_wait_q  <= {PERF_W{1'b0}};
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_wait_q  <= perf_wait_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
    assign perf_wait  = perf_wait_q;
`else
    assign perf_stall = {PERF_W{1'b0}};
    assign perf_flush = {PERF_W{1'b0}};
    assign perf_wait  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut A uses LU_BUBBLES=1/MEM_TIMEOUT=255, dut B uses 3/3.
module tb_hazard_ctrl;

    // Control vector order: {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold}
    localparam logic [5:0] NORM = 6'b110000;
    localparam logic [5:0] BUB  = 6'b000100;
    localparam logic [5:0] BR   = 6'b111110;
    localparam logic [5:0] FRZ  = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_uses_rt, idex_memread, br, busy;

    logic        a_pc_we, a_ifid_we, a_ifid_flush, a_idex_flush, a_exmem_flush, a_hold, a_to;
    logic        b_pc_we, b_ifid_we, b_ifid_flush, b_idex_flush, b_exmem_flush, b_hold, b_to;
    logic [1:0]  a_st, b_st;
    logic [15:0] a_ps, a_pf, a_pw, b_ps, b_pf, b_pw;
    logic [5:0]  ctl_a, ctl_b;

    int tests_run = 0;
    int fails = 0;

    assign ctl_a = {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_flush, a_exmem_flush, a_hold};
    assign ctl_b = {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_flush, b_exmem_flush, b_hold};

    hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(255)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_branch_taken(br),
        .dmem_busy(busy), .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush), .pipe_hold(a_hold),
        .timeout_err(a_to), .state_o(a_st), .perf_stall(a_ps), .perf_flush(a_pf),
        .perf_wait(a_pw)
    );

    hazard_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_branch_taken(br),
        .dmem_busy(busy), .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush), .pipe_hold(b_hold),
        .timeout_err(b_to), .state_o(b_st), .perf_stall(b_ps), .perf_flush(b_pf),
        .perf_wait(b_pw)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // add $3,$1,$2 in ID, nothing interesting in EX
    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        idex_memread = 1'b0; idex_rt = 5'd3; br = 1'b0; busy = 1'b0;
    endtask

    // lw $5 in EX, add rs=$5 in ID
    task automatic set_lu();
        idle();
        idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_lu();
        br = 1'b1;
        #3;
        tests_run++; if (ctl_a !== NORM) begin fails++; $display("FAIL reset_ctl_a got %b exp %b", ctl_a, NORM); end
        tests_run++; if (ctl_b !== NORM) begin fails++; $display("FAIL reset_ctl_b got %b exp %b", ctl_b, NORM); end
        tests_run++; if (a_st !== 2'd0 || b_st !== 2'd0) begin fails++; $display("FAIL reset_state got %0d/%0d exp 0", a_st, b_st); end
        tests_run++; if (a_to !== 1'b0 || b_to !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b/%b exp 0", a_to, b_to); end
        tests_run++;
        if ({a_ps, a_pf, a_pw, b_ps, b_pf, b_pw} !== 96'd0) begin
            fails++; $display("FAIL reset_perf got %h %h %h %h %h %h exp 0", a_ps, a_pf, a_pw, b_ps, b_pf, b_pw);
        end
        idle();
        #9 rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_hazard();
        for (int i = 0; i < 4; i++) begin
            idle();
            #1;
            tests_run++; if (ctl_a !== NORM || ctl_b !== NORM) begin fails++; $display("FAIL nohaz_ctl[%0d] got %b/%b exp %b", i, ctl_a, ctl_b, NORM); end
            tests_run++; if (a_st !== 2'd0 || b_st !== 2'd0) begin fails++; $display("FAIL nohaz_state[%0d] got %0d/%0d exp 0", i, a_st, b_st); end
            step();
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_lu(); else idle();
            #1;
            tests_run++; if (ctl_a !== ((i == 0) ? BUB : NORM)) begin fails++; $display("FAIL lu1_ctl[%0d] got %b exp %b", i, ctl_a, (i == 0) ? BUB : NORM); end
            tests_run++; if (ctl_b !== ((i < 3) ? BUB : NORM)) begin fails++; $display("FAIL lu3_ctl[%0d] got %b exp %b", i, ctl_b, (i < 3) ? BUB : NORM); end
            tests_run++; if (b_st !== ((i == 1 || i == 2) ? 2'd1 : 2'd0)) begin fails++; $display("FAIL lu3_state[%0d] got %0d", i, b_st); end
            step();
        end
        // rt match but the ID instruction does not read rt
        idle(); id_uses_rt = 1'b0; id_rt = 5'd7; idex_memread = 1'b1; idex_rt = 5'd7;
        #1;
        tests_run++; if (ctl_a !== NORM || ctl_b !== NORM) begin fails++; $display("FAIL lu_rt_unused got %b/%b exp %b", ctl_a, ctl_b, NORM); end
        step();
        // load into $zero never stalls
        idle(); idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        #1;
        tests_run++; if (ctl_a !== NORM || ctl_b !== NORM) begin fails++; $display("FAIL lu_zero got %b/%b exp %b", ctl_a, ctl_b, NORM); end
        step();
        idle(); id_rt = 5'd7; idex_memread = 1'b1; idex_rt = 5'd7;
        #1;
        tests_run++; if (ctl_a !== BUB) begin fails++; $display("FAIL lu_rt_hit got %b exp %b", ctl_a, BUB); end
        step();
        idle();
        step(); step(); step();
        tests_run++; if (b_st !== 2'd0 || ctl_b !== NORM) begin fails++; $display("FAIL lu_rt_done got %0d/%b exp 0/%b", b_st, ctl_b, NORM); end
    endtask

    task automatic test_branch();
        logic [15:0] exp_pf;
        set_lu(); br = 1'b1;
        #1;
        tests_run++; if (ctl_a !== BR || ctl_b !== BR) begin fails++; $display("FAIL br_lu got %b/%b exp %b", ctl_a, ctl_b, BR); end
        step();
        idle();
        #1;
        tests_run++; if (ctl_a !== NORM || ctl_b !== NORM || b_st !== 2'd0) begin fails++; $display("FAIL br_no_stall got %b/%b st %0d", ctl_a, ctl_b, b_st); end
        step();
        set_lu();
        step();
        idle(); br = 1'b1;
        #1;
        tests_run++; if (ctl_b !== BR || b_st !== 2'd1) begin fails++; $display("FAIL br_in_stall got %b st %0d exp %b st 1", ctl_b, b_st, BR); end
        step();
        idle();
        #1;
        tests_run++; if (ctl_b !== NORM || b_st !== 2'd0) begin fails++; $display("FAIL br_abort got %b st %0d exp %b st 0", ctl_b, b_st, NORM); end
`ifdef HAZARD_PERF_EN
        exp_pf = 16'd2;
`else
        exp_pf = 16'd0;
`endif
        tests_run++; if (a_pf !== exp_pf) begin fails++; $display("FAIL br_perf_flush got %0d exp %0d", a_pf, exp_pf); end
        step();
    endtask

    task automatic test_mem_wait();
        logic [15:0] exp_pw;
        for (int i = 0; i < 6; i++) begin
            idle();
            busy = (i < 4);
            br = (i >= 2);
            #1;
            tests_run++; if (ctl_a !== ((i < 5) ? FRZ : BR)) begin fails++; $display("FAIL wait_ctl[%0d] got %b exp %b", i, ctl_a, (i < 5) ? FRZ : BR); end
            tests_run++; if (a_st !== ((i == 0 || i == 5) ? 2'd0 : 2'd2)) begin fails++; $display("FAIL wait_state[%0d] got %0d", i, a_st); end
            step();
        end
        idle();
        #1;
`ifdef HAZARD_PERF_EN
        exp_pw = 16'd4;
`else
        exp_pw = 16'd0;
`endif
        tests_run++; if (a_to !== 1'b0) begin fails++; $display("FAIL wait_no_timeout got %b exp 0", a_to); end
        tests_run++; if (a_pw !== exp_pw) begin fails++; $display("FAIL wait_perf got %0d exp %0d", a_pw, exp_pw); end
        step();
    endtask

    task automatic test_timeout();
        pulse_reset();
        step();
        for (int k = 1; k <= 10; k++) begin
            idle(); busy = 1'b1;
            #1;
            tests_run++; if (b_to !== (k >= 5)) begin fails++; $display("FAIL to_flag[%0d] got %b exp %b", k, b_to, (k >= 5)); end
            tests_run++; if (b_st !== ((k == 1) ? 2'd0 : 2'd2)) begin fails++; $display("FAIL to_state[%0d] got %0d", k, b_st); end
            step();
        end
        idle();
        #1;
        tests_run++; if (ctl_b !== FRZ || b_to !== 1'b1) begin fails++; $display("FAIL to_exit got %b/%b exp %b/1", ctl_b, b_to, FRZ); end
        step();
        #1;
        tests_run++; if (ctl_b !== NORM || b_to !== 1'b1 || a_to !== 1'b0) begin fails++; $display("FAIL to_sticky got %b/%b a %b", ctl_b, b_to, a_to); end
        pulse_reset();
        #1;
        tests_run++; if (b_to !== 1'b0) begin fails++; $display("FAIL to_clear got %b exp 0", b_to); end
        step();
    endtask

    task automatic test_stall_wait();
        logic [5:0] exp_c;
        logic [1:0] exp_s;
        logic [15:0] all_perf;
        pulse_reset();
        step();
        for (int i = 0; i < 7; i++) begin
            if (i == 0) set_lu(); else idle();
            busy = (i == 1 || i == 2);
            case (i)
                0:       begin exp_c = BUB;  exp_s = 2'd0; end
                1:       begin exp_c = FRZ;  exp_s = 2'd1; end
                2, 3:    begin exp_c = FRZ;  exp_s = 2'd2; end
                4, 5:    begin exp_c = BUB;  exp_s = 2'd1; end
                default: begin exp_c = NORM; exp_s = 2'd0; end
            endcase
            #1;
            tests_run++; if (ctl_b !== exp_c) begin fails++; $display("FAIL sw_ctl[%0d] got %b exp %b", i, ctl_b, exp_c); end
            tests_run++; if (b_st !== exp_s) begin fails++; $display("FAIL sw_state[%0d] got %0d exp %0d", i, b_st, exp_s); end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            idle(); busy = 1'b1;
            step();
        end
        tests_run++; if (b_st !== 2'd2 || b_to !== 1'b1) begin fails++; $display("FAIL arst_pre got st %0d to %b exp 2/1", b_st, b_to); end
        #2 rst_n = 1'b0;
        #1;
        all_perf = a_ps | a_pf | a_pw | b_ps | b_pf | b_pw;
        tests_run++; if (a_st !== 2'd0 || b_st !== 2'd0) begin fails++; $display("FAIL arst_state got %0d/%0d exp 0", a_st, b_st); end
        tests_run++; if (ctl_a !== NORM || ctl_b !== NORM) begin fails++; $display("FAIL arst_ctl got %b/%b exp %b", ctl_a, ctl_b, NORM); end
        tests_run++; if (b_to !== 1'b0 || all_perf !== 16'd0) begin fails++; $display("FAIL arst_cnt got to %b perf %h exp 0", b_to, all_perf); end
        #1 rst_n = 1'b1;
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_stall_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and inserts bubbles. It flushes the younger stages when a branch resolves taken in MEM. It freezes the whole pipeline while data memory reports busy. It drives the write-enable and flush controls of PC, IF_ID, ID_EX and EX_MEM, and the hold control of ID_EX, EX_MEM and MEM_WB.

Parameters:
LU_BUBBLES, 1, number of bubbles inserted per load-use hazard; legal range 1..7.
MEM_TIMEOUT, 255, MEM_WAIT cycle count at which timeout_err is raised; legal range 1..255.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
id_rs  in  5  rs field of the instruction in ID (IF_ID instruction [25:21]).
id_rt  in  5  rt field of the instruction in ID (IF_ID instruction [20:16]).
id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
idex_memread  in  1  instruction in EX is a load.
idex_rt  in  5  destination rt of the instruction in EX.
exmem_branch_taken  in  1  branch AND zero-flag, resolved in MEM.
dmem_busy  in  1  data memory cannot complete this cycle.
pc_we  out  1  PC load enable.
ifid_we  out  1  IF_ID load enable.
ifid_flush  out  1  IF_ID clears to NOP on next edge.
idex_flush  out  1  ID_EX control fields clear to zero (bubble).
exmem_flush  out  1  EX_MEM control fields clear to zero.
pipe_hold  out  1  ID_EX, EX_MEM and MEM_WB hold their contents.
timeout_err  out  1  sticky memory-wait timeout flag.
state_o  out  2  current FSM state, for debug.
perf_stall  out  16  load-use bubble cycles (HAZARD_PERF_EN).
perf_flush  out  16  branch flush events (HAZARD_PERF_EN).
perf_wait  out  16  MEM_WAIT cycles (HAZARD_PERF_EN).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, lu_cnt=0, wait_cnt=0, ret_state=RUN, timeout_err=0, perf counters=0.
  - Outputs while in reset: pc_we=1, ifid_we=1, all flushes=0, pipe_hold=0.
- Hazard term: lu_hit = idex_memread & (idex_rt!=0) & ((idex_rt==id_rs) | (id_uses_rt & (idex_rt==id_rt))).
- Outputs are combinational from state and inputs; state updates on the clk rising edge.
- Default output values: pc_we=1, ifid_we=1, flushes=0, pipe_hold=0.
- Priority in every state: dmem_busy, then exmem_branch_taken, then lu_hit.
- Freeze set (on dmem_busy): pc_we=0, ifid_we=0, pipe_hold=1, all flushes=0.
- RUN (state 0):
  - dmem_busy: freeze set; ret_state<=RUN; wait_cnt<=1; go to MEM_WAIT.
  - Else exmem_branch_taken: ifid_flush=idex_flush=exmem_flush=1, pc_we=1 (PC loads the branch target); stay in RUN.
  - Else lu_hit: pc_we=0, ifid_we=0, idex_flush=1.
    - LU_BUBBLES==1: stay in RUN.
    - LU_BUBBLES>1: lu_cnt<=LU_BUBBLES-1; go to LU_STALL.
- LU_STALL (state 1):
  - Outputs: pc_we=0, ifid_we=0, idex_flush=1; lu_cnt decrements each cycle.
  - lu_cnt==1: go to RUN.
  - exmem_branch_taken: branch flush outputs as in RUN; stall aborted, lu_cnt<=0, go to RUN.
  - dmem_busy: freeze set; ret_state<=LU_STALL; lu_cnt is preserved; go to MEM_WAIT.
- MEM_WAIT (state 2):
  - Outputs: freeze set on every cycle, including the exit cycle, giving one recovery cycle.
  - wait_cnt saturates at 255; when wait_cnt reaches MEM_TIMEOUT, timeout_err<=1 until reset.
  - !dmem_busy: go to ret_state; wait_cnt<=0.
  - exmem_branch_taken is ignored while frozen; it is re-evaluated after exit because EX_MEM was held.
- State code 3 is illegal: it behaves as RUN and transitions to RUN.
- No combinational path exists from any output back to any input.

Optional Feature:
HAZARD_PERF_EN:
- Defined:
  - perf_stall increments in every cycle with idex_flush=1 and no branch flush.
  - perf_flush increments once per taken-branch flush cycle.
  - perf_wait increments in every MEM_WAIT cycle.
  - All three counters are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: the three counter registers are not built; the outputs are tied to 0 and the port list is unchanged.

Decomposition:
- Package hazard_ctrl_pkg holds:
  - the state encoding (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2);
  - REG_W=5;
  - PERF_W=16;
  - WAIT_W=8.
- Sub-module load_use_detect: a purely combinational comparator that produces lu_hit. The FSM, counters and output decode stay in hazard_ctrl.

Test Plan:
1. Reset release, no hazards (add $3,$1,$2 stream) -> pc_we=1, ifid_we=1, flushes=0, pipe_hold=0 every cycle; state_o=0.
2. lw $5,0($1) in EX (idex_memread=1, idex_rt=5), ID add rs=5 -> exactly one cycle with pc_we=0, ifid_we=0, idex_flush=1, then normal flow. Repeat with LU_BUBBLES=3 -> 3 bubble cycles, state_o=1 for 2 cycles. Repeat with idex_rt=0 -> no stall.
3. exmem_branch_taken=1 coincident with lu_hit -> ifid_flush=idex_flush=exmem_flush=1, pc_we=1; no stall follows.
4. dmem_busy high for 4 cycles -> pipe_hold=1 and pc_we=0 for 5 cycles (4 plus 1 recovery); timeout_err stays 0; perf_wait=4 with HAZARD_PERF_EN.
5. MEM_TIMEOUT=3, dmem_busy held 10 cycles -> timeout_err rises after the 3rd MEM_WAIT cycle and stays 1 after busy drops, until rst_n pulse.
6. dmem_busy asserted mid LU_STALL (LU_BUBBLES=3, lu_cnt=2) -> after busy drops and the recovery cycle, the 2 remaining bubbles complete; async rst_n low mid-MEM_WAIT -> immediate RUN, all counters 0.
